// File: rtl/spec_pkg.sv
// Shared types and width helpers for the spectrum framing controller.
// Holds the framer state encoding and magnitude/bin width functions.
package spec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAST = 2'd2
   } frm_state_t;

   // re^2 + im^2 needs one bit more than a single square
   function automatic int mag_w(input int fft_w);
      return 2 * fft_w + 1;
   endfunction

   function automatic int sq_w(input int fft_w);
      return 2 * fft_w;
   endfunction

   function automatic int bin_w(input int fft_len);
      return $clog2(fft_len);
   endfunction

endpackage

// File: rtl/spec_mag_sq.sv
// Two-stage |X|^2 pipeline: squares, then sum.
// Framing bits travel alongside so they stay aligned with the data.
module spec_mag_sq
   import spec_pkg::*;
#(
   parameter int FFT_W = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sop,
   input  logic                      in_eop,
   input  logic signed [FFT_W-1:0]   in_re,
   input  logic signed [FFT_W-1:0]   in_im,
   output logic                      out_valid,
   output logic                      out_sop,
   output logic                      out_eop,
   output logic [mag_w(FFT_W)-1:0]   out_mag
);

   localparam int SQ_W = sq_w(FFT_W);

   logic signed [SQ_W-1:0] re_x;
   logic signed [SQ_W-1:0] im_x;
   logic [SQ_W-1:0]        re_sq;
   logic [SQ_W-1:0]        im_sq;
   logic                   v1;
   logic                   s1;
   logic                   e1;

   // widen before multiplying so -2^(W-1) squared cannot wrap
   assign re_x = {{FFT_W{in_re[FFT_W-1]}}, in_re};
   assign im_x = {{FFT_W{in_im[FFT_W-1]}}, im_x_lo()};

   function automatic logic [FFT_W-1:0] im_x_lo();
      return in_im;
   endfunction

   // stage 1: squares plus delayed framing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         re_sq <= '0;
         im_sq <= '0;
         v1    <= 1'b0;
         s1    <= 1'b0;
         e1    <= 1'b0;
      end else begin
         re_sq <= unsigned'(re_x * re_x);
         im_sq <= unsigned'(im_x * im_x);
         v1    <= in_valid;
         s1    <= in_sop;
         e1    <= in_eop;
      end
   end

   // stage 2: sum of squares plus delayed framing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_mag   <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end else begin
         out_mag   <= {1'b0, re_sq} + {1'b0, im_sq};
         out_valid <= v1;
         out_sop   <= s1;
         out_eop   <= e1;
      end
   end

endmodule

// File: rtl/spec_frame_ctrl.sv
// ADC-to-FFT framer with overrun detect and FFT magnitude stream.
// Optional per-frame peak search is built when SPEC_PEAK_EN is defined.
module spec_frame_ctrl
   import spec_pkg::*;
#(
   parameter int ADC_W   = 10,
   parameter int FFT_W   = 12,
   parameter int FFT_LEN = 1024,
   parameter int BIN_W   = $clog2(FFT_LEN)
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic                      frm_en,
   input  logic [ADC_W-1:0]          adc_data,
   input  logic                      adc_valid,
   input  logic                      sink_ready,
   output logic                      sink_valid,
   output logic                      sink_sop,
   output logic                      sink_eop,
   output logic signed [FFT_W-1:0]   sink_real,
   input  logic                      src_valid,
   input  logic                      src_sop,
   input  logic                      src_eop,
   input  logic signed [FFT_W-1:0]   src_real,
   input  logic signed [FFT_W-1:0]   src_imag,
   output logic                      mag_valid,
   output logic                      mag_sop,
   output logic                      mag_eop,
   output logic [mag_w(FFT_W)-1:0]   mag_data,
   output logic [BIN_W-1:0]          mag_bin,
   output logic                      peak_valid,
   output logic [BIN_W-1:0]          peak_bin,
   output logic [mag_w(FFT_W)-1:0]   peak_mag,
   output logic                      ovr_flag,
   input  logic                      ovr_clr
);

   localparam int MAG_W = mag_w(FFT_W);
   localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FFT_LEN - 1);
   localparam logic [BIN_W-1:0] PRE_LAST = BIN_W'(FFT_LEN - 2);

   logic [ADC_W-1:0] adc_flip;
   logic [FFT_W-1:0] conv_w;
   logic             conv_valid;
   logic [FFT_W-1:0] conv_data;

   frm_state_t       state;
   frm_state_t       state_nxt;
   logic             hold_valid;
   logic [FFT_W-1:0] hold_data;
   logic [BIN_W-1:0] xfer_cnt;
   logic             hs;
   logic             hold_free;
   logic             load;
   logic             drop;

   logic [BIN_W-1:0] bin_nxt;

   // offset-binary to two's complement is an MSB flip
   assign adc_flip = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};

   if (FFT_W >= ADC_W + 1) begin : g_sext
      assign conv_w = {{(FFT_W-ADC_W){adc_flip[ADC_W-1]}}, adc_flip};
   end else begin : g_trunc
      $warning("spec_frame_ctrl: FFT_W < ADC_W+1, sample MSBs truncated");
      assign conv_w = adc_flip[FFT_W-1:0];
   end

   // conversion register: one cycle from strobe to framer
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         conv_valid <= 1'b0;
         conv_data  <= '0;
      end else begin
         conv_valid <= adc_valid;
         if (adc_valid) begin
            conv_data <= conv_w;
         end
      end
   end

   assign hs        = hold_valid && sink_ready;
   assign hold_free = !hold_valid || sink_ready;

   // framer next state and holding-register load/drop decisions
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      drop      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (conv_valid && frm_en && sink_ready) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (conv_valid) begin
               load = hold_free;
               drop = !hold_free;
            end
            if (hs && xfer_cnt == PRE_LAST) begin
               state_nxt = ST_LAST;
            end
         end
         ST_LAST: begin
            if (!hold_valid) begin
               load = conv_valid;
            end else if (hs) begin
               state_nxt = frm_en ? ST_RUN : ST_IDLE;
               load      = conv_valid && frm_en;
            end else begin
               drop = conv_valid;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // framer state, holding register and transfer counter
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         hold_valid <= 1'b0;
         hold_data  <= '0;
         xfer_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            hold_valid <= 1'b1;
            hold_data  <= conv_data;
         end else if (hs) begin
            hold_valid <= 1'b0;
         end
         if (hs) begin
            xfer_cnt <= (xfer_cnt == LAST_IDX) ? '0
                                               : xfer_cnt + BIN_W'(1);
         end
      end
   end

   assign sink_valid = hold_valid;
   assign sink_real  = hold_data;
   assign sink_sop   = hold_valid && (xfer_cnt == '0);
   assign sink_eop   = hold_valid && (xfer_cnt == LAST_IDX);

   // sticky overrun; a new drop outranks a simultaneous clear
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ovr_flag <= 1'b0;
      end else if (drop) begin
         ovr_flag <= 1'b1;
      end else if (ovr_clr) begin
         ovr_flag <= 1'b0;
      end
   end

   spec_mag_sq #(
      .FFT_W (FFT_W)
   ) u_mag (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .in_valid  (src_valid),
      .in_sop    (src_sop),
      .in_eop    (src_eop),
      .in_re     (src_real),
      .in_im     (src_imag),
      .out_valid (mag_valid),
      .out_sop   (mag_sop),
      .out_eop   (mag_eop),
      .out_mag   (mag_data)
   );

   assign mag_bin = (!mag_valid || mag_sop) ? '0 : bin_nxt;

   // bin index for the next magnitude sample
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bin_nxt <= '0;
      end else if (mag_valid) begin
         if (mag_sop) begin
            bin_nxt <= BIN_W'(1);
         end else begin
            bin_nxt <= (bin_nxt == LAST_IDX) ? '0
                                             : bin_nxt + BIN_W'(1);
         end
      end
   end

`ifdef SPEC_PEAK_EN

   logic             first_pend;
   logic [MAG_W-1:0] best_mag;
   logic [BIN_W-1:0] best_bin;
   logic             take;
   logic [MAG_W-1:0] base_mag;
   logic [BIN_W-1:0] base_bin;
   logic [MAG_W-1:0] cand_mag;
   logic [BIN_W-1:0] cand_bin;

   // running maximum including the current sample; DC never competes
   always_comb begin
      take     = 1'b0;
      base_mag = best_mag;
      base_bin = best_bin;
      if (mag_sop) begin
         base_mag = '0;
         base_bin = '0;
      end
      if (mag_valid && !mag_sop) begin
         take = first_pend || (mag_data > best_mag);
      end
      cand_mag = take ? mag_data : base_mag;
      cand_bin = take ? mag_bin  : base_bin;
   end

   // per-frame tracker and held peak result
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         first_pend <= 1'b1;
         best_mag   <= '0;
         best_bin   <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
      end else begin
         peak_valid <= mag_valid && mag_eop;
         if (mag_valid) begin
            best_mag <= cand_mag;
            best_bin <= cand_bin;
            if (mag_sop) begin
               first_pend <= 1'b1;
            end else if (take) begin
               first_pend <= 1'b0;
            end
            if (mag_eop) begin
               peak_mag <= cand_mag;
               peak_bin <= cand_bin;
            end
         end
      end
   end

`else

   assign peak_valid = 1'b0;
   assign peak_bin   = '0;
   assign peak_mag   = '0;

`endif

endmodule

// File: tb/tb_spec_frame_ctrl.sv
// Self-checking bench for spec_frame_ctrl (FFT_LEN=8, ADC_W=10, FFT_W=12).
// Build with or without SPEC_PEAK_EN; peak expectations follow the define.
module tb_spec_frame_ctrl;

   localparam int L = 8;

   logic               clk = 1'b0;
   logic               sys_rst_n = 1'b0;
   logic               frm_en = 1'b0;
   logic [9:0]         adc_data = '0;
   logic               adc_valid = 1'b0;
   logic               sink_ready = 1'b0;
   logic               sink_valid;
   logic               sink_sop;
   logic               sink_eop;
   logic signed [11:0] sink_real;
   logic               src_valid = 1'b0;
   logic               src_sop = 1'b0;
   logic               src_eop = 1'b0;
   logic signed [11:0] src_real = '0;
   logic signed [11:0] src_imag = '0;
   logic               mag_valid;
   logic               mag_sop;
   logic               mag_eop;
   logic [24:0]        mag_data;
   logic [2:0]         mag_bin;
   logic               peak_valid;
   logic [2:0]         peak_bin;
   logic [24:0]        peak_mag;
   logic               ovr_flag;
   logic               ovr_clr = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   int src_bin = 0;
   int xfer_idx = 0;
   int exp_q[$];

   typedef struct {
      bit     v;
      bit     s;
      bit     e;
      longint m;
      int     b;
      bit     pv;
      int     pb;
      longint pm;
   } rec_t;

   rec_t   h[4];
   longint fm[L];
   bit     fv[L];

   spec_frame_ctrl #(
      .ADC_W   (10),
      .FFT_W   (12),
      .FFT_LEN (L)
   ) dut (
      .sys_clk    (clk),
      .sys_rst_n  (sys_rst_n),
      .frm_en     (frm_en),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .sink_ready (sink_ready),
      .sink_valid (sink_valid),
      .sink_sop   (sink_sop),
      .sink_eop   (sink_eop),
      .sink_real  (sink_real),
      .src_valid  (src_valid),
      .src_sop    (src_sop),
      .src_eop    (src_eop),
      .src_real   (src_real),
      .src_imag   (src_imag),
      .mag_valid  (mag_valid),
      .mag_sop    (mag_sop),
      .mag_eop    (mag_eop),
      .mag_data   (mag_data),
      .mag_bin    (mag_bin),
      .peak_valid (peak_valid),
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag),
      .ovr_flag   (ovr_flag),
      .ovr_clr    (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act,
                      input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int v);
      adc_valid = 1'b1;
      adc_data  = 10'(v);
   endtask

   // model of the magnitude/peak stream, compared every cycle
   always @(negedge clk) begin
      rec_t r;
      bit   found;
      if (!sys_rst_n) begin
         chk("rst_sink_out",
             longint'({sink_valid, sink_sop, sink_eop, sink_real}), 0);
         chk("rst_mag_out",
             longint'({mag_valid, mag_sop, mag_eop, mag_data, mag_bin}), 0);
         chk("rst_misc_out",
             longint'({peak_valid, peak_bin, peak_mag, ovr_flag}), 0);
         chk("rst_pending_q", exp_q.size(), 0);
         exp_q.delete();
         xfer_idx = 0;
         for (int i = 0; i < 4; i++) h[i] = '{default: 0};
      end else begin
         r = '{default: 0};
         r.v = src_valid;
         r.s = src_sop;
         r.e = src_eop;
         r.b = src_bin;
         r.m = longint'(src_real) * longint'(src_real)
             + longint'(src_imag) * longint'(src_imag);
         if (r.v) begin
            if (r.s) for (int k = 0; k < L; k++) fv[k] = 1'b0;
            fm[r.b] = r.m;
            fv[r.b] = 1'b1;
            if (r.e) begin
               r.pv = 1'b1;
               found = 1'b0;
               for (int k = 1; k < L; k++) begin
                  if (fv[k] && (!found || fm[k] > r.pm)) begin
                     found = 1'b1;
                     r.pm = fm[k];
                     r.pb = k;
                  end
               end
            end
         end
         h[3] = h[2];
         h[2] = h[1];
         h[1] = h[0];
         h[0] = r;
         chk("mag_valid", mag_valid, h[2].v);
         chk("mag_sop", mag_sop, h[2].s);
         chk("mag_eop", mag_eop, h[2].e);
         if (h[2].v) begin
            chk("mag_data", mag_data, h[2].m);
            chk("mag_bin", mag_bin, h[2].b);
         end
`ifdef SPEC_PEAK_EN
         chk("peak_valid", peak_valid, h[3].pv);
         if (h[3].pv) begin
            chk("peak_bin", peak_bin, h[3].pb);
            chk("peak_mag", peak_mag, h[3].pm);
         end
`else
         chk("peak_tied", longint'({peak_valid, peak_bin, peak_mag}), 0);
`endif
         if (sink_valid && sink_ready) begin
            chk("sink_hs_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               chk("sink_real", sink_real, exp_q.pop_front());
               chk("sink_sop", sink_sop, (xfer_idx % L) == 0);
               chk("sink_eop", sink_eop, (xfer_idx % L) == L - 1);
            end
            xfer_idx++;
         end else if (!sink_valid) begin
            chk("sink_framing_idle", {sink_sop, sink_eop}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by %0t, expected earlier", $time);
      $fatal(1);
   end

   initial begin
      int fre[16];
      int fim[16];
      int base;
      bit hit;
      fre = '{3, -2048, 2047, -1, 0, 100, 7, 2047,
              6, 1, 3, 0, 1, 0, 0, 0};
      fim = '{4, -2048, -2048, 1, 0, -50, 7, 2047,
              8, 2, 0, -3, 0, 0, 0, 0};

      repeat (3) cyc();
      sys_rst_n  = 1'b1;
      sink_ready = 1'b1;
      cyc();

      // conversion corner values inside one frame
      for (int t = 0; t < 14; t++) begin
         int v[8];
         v = '{0, 512, 1023, 100, 200, 300, 400, 1000};
         cyc();
         adc_valid = 1'b0;
         frm_en    = (t < 8);
         if (t < 8) strobe(v[t]);
         if (t == 0) exp_q.push_back(-512);
         if (t == 1) exp_q.push_back(0);
         if (t == 2) exp_q.push_back(511);
         if (t >= 3 && t < 8) exp_q.push_back(v[t] - 512);
      end
      chk("q_drained_conv", exp_q.size(), 0);
      chk("ovr_after_conv", ovr_flag, 0);

      // 20 strobes, frm_en dropped mid second frame: exactly two frames
      for (int t = 0; t < 26; t++) begin
         cyc();
         adc_valid = 1'b0;
         frm_en    = (t < 12);
         if (t < 20) strobe((t * 53 + 7) % 1024);
         if (t < 16) exp_q.push_back((t * 53 + 7) % 1024 - 512);
      end
      chk("q_drained_two_frames", exp_q.size(), 0);
      chk("two_frames_count", xfer_idx, 24);
      chk("ovr_after_two_frames", ovr_flag, 0);

      // backpressure for 3 cycles: samples 3..5 dropped
      for (int t = 0; t < 18; t++) begin
         cyc();
         adc_valid  = 1'b0;
         frm_en     = (t <= 10);
         sink_ready = !(t >= 4 && t <= 6);
         if (t <= 10) strobe(t * 90 + 5);
         if (t <= 2 || (t >= 6 && t <= 10))
            exp_q.push_back(t * 90 + 5 - 512);
      end
      chk("q_drained_stall", exp_q.size(), 0);
      chk("stall_frame_count", xfer_idx, 32);
      chk("ovr_set", ovr_flag, 1);
      cyc();
      ovr_clr = 1'b1;
      cyc();
      ovr_clr = 1'b0;
      chk("ovr_cleared", ovr_flag, 0);

      // magnitude stream: two back-to-back frames
      for (int j = 0; j < 16; j++) begin
         cyc();
         src_valid = 1'b1;
         src_sop   = (j % L) == 0;
         src_eop   = (j % L) == L - 1;
         src_real  = 12'(fre[j]);
         src_imag  = 12'(fim[j]);
         src_bin   = j % L;
         @(negedge clk);
         if (j == 2) chk("mag_lit_3_4", mag_data, 25);
         if (j == 3) chk("mag_lit_fullscale", mag_data, 8388608);
      end
      for (int m = 1; m <= 4; m++) begin
         cyc();
         src_valid = 1'b0;
         src_sop   = 1'b0;
         src_eop   = 1'b0;
         @(negedge clk);
         if (m == 2) chk("mag_eop_lit", mag_eop, 1);
`ifdef SPEC_PEAK_EN
         if (m == 2) chk("peak_not_early", peak_valid, 0);
         if (m == 3) begin
            chk("peak_valid_lit", peak_valid, 1);
            chk("peak_bin_lit", peak_bin, 2);
            chk("peak_mag_lit", peak_mag, 9);
         end
`else
         if (m == 3) chk("peak_absent_lit", peak_valid, 0);
`endif
      end

      // reset asserted once transfer 4 is due
      base = xfer_idx;
      hit  = 1'b0;
      frm_en = 1'b1;
      for (int t = 0; t < 40 && !hit; t++) begin
         cyc();
         if (xfer_idx - base == 4) begin
            hit = 1'b1;
         end else begin
            adc_valid = 1'b0;
            strobe(t * 7 + 300);
            if (t < 4) exp_q.push_back(t * 7 + 300 - 512);
            src_valid = 1'b1;
            src_sop   = 1'b1;
            src_eop   = 1'b1;
            src_real  = 12'sd5;
            src_imag  = 12'sd5;
            src_bin   = 0;
         end
      end
      chk("rst_trigger_reached", hit, 1);
      adc_valid = 1'b0;
      src_valid = 1'b0;
      src_sop   = 1'b0;
      src_eop   = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      chk("rst_now_sink_valid", sink_valid, 0);
      chk("rst_now_sink_eop", sink_eop, 0);
      chk("rst_now_mag_valid", mag_valid, 0);
      repeat (2) cyc();
      sys_rst_n = 1'b1;

      // idle restart rules: no ready, then no enable
      for (int t = 0; t < 5; t++) begin
         cyc();
         adc_valid  = 1'b0;
         frm_en     = 1'b1;
         sink_ready = 1'b0;
         if (t == 0) strobe(77);
      end
      for (int t = 0; t < 5; t++) begin
         cyc();
         adc_valid  = 1'b0;
         frm_en     = 1'b0;
         sink_ready = 1'b1;
         if (t == 0) strobe(88);
      end
      chk("idle_no_transfer", xfer_idx, 0);

      // fresh frame after reset starts at transfer 0
      for (int t = 0; t < 14; t++) begin
         cyc();
         adc_valid = 1'b0;
         frm_en    = (t < 8);
         if (t < 8) begin
            strobe(t * 111 + 20);
            exp_q.push_back(t * 111 + 20 - 512);
         end
      end
      chk("q_drained_after_rst", exp_q.size(), 0);
      chk("after_rst_count", xfer_idx, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/spec_frame_ctrl.md
SPEC_FRAME_CTRL -- requirements
Module: spec_frame_ctrl

Interface
REQ-001 Parameter ADC_W, default 10, ADC sample width (offset-binary).
REQ-002 Parameter FFT_W, default 12, FFT sample width (two's complement).
REQ-003 Parameter FFT_LEN, default 1024, points per frame; power of 2, 8..65536.
REQ-004 Parameter BIN_W, default $clog2(FFT_LEN), bin index width.
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frm_en  in  1  framing enable.
REQ-008 adc_data  in  ADC_W  ADC sample.
REQ-009 adc_valid  in  1  one-cycle strobe per ADC sample.
REQ-010 sink_ready  in  1  FFT core accepts data.
REQ-011 sink_valid, sink_sop, sink_eop  out  1 each  FFT input framing.
REQ-012 sink_real  out  FFT_W  signed sample to FFT; imaginary input is tied to zero by the integrator.
REQ-013 src_valid, src_sop, src_eop  in  1 each  FFT output framing; FFT source_ready is tied high.
REQ-014 src_real, src_imag  in  FFT_W  signed FFT output.
REQ-015 mag_valid, mag_sop, mag_eop  out  1 each  magnitude stream framing.
REQ-016 mag_data  out  2*FFT_W+1  unsigned re^2+im^2; mag_bin  out  BIN_W  bin index.
REQ-017 peak_valid  out  1; peak_bin  out  BIN_W; peak_mag  out  2*FFT_W+1.
REQ-018 ovr_flag  out  1  sticky sample-overrun flag; ovr_clr  in  1  clears it.

Function
REQ-019 Conversion: sample = adc_data - 2^(ADC_W-1), sign-extended (FFT_W>=ADC_W+1), or MSB-truncated with a warning otherwise; registered, 1 cycle.
REQ-020 Framer FSM states IDLE, RUN, LAST; IDLE->RUN on first converted sample while frm_en=1 and sink_ready=1; samples arriving in IDLE otherwise are discarded.
REQ-021 The sample holding register presents sink_valid=1 until sink_valid&&sink_ready; the transfer counter advances only on that handshake.
REQ-022 sink_sop=1 on transfer 0 and sink_eop=1 on transfer FFT_LEN-1, both only while sink_valid=1.
REQ-023 RUN->LAST when the counter reaches FFT_LEN-1; LAST->RUN after the eop handshake if frm_en=1, else LAST->IDLE; frm_en deassertion mid-frame always completes the frame.
REQ-024 A new sample arriving while the holding register is full is dropped and ovr_flag is set; ovr_flag holds until ovr_clr; if set and clear coincide, set wins.
REQ-025 Magnitude: 2-stage pipeline (squares registered, then sum); mag_* outputs lag src_* by exactly 2 cycles with framing bits delayed alike.
REQ-026 mag_bin is 0 on mag_sop and increments per mag_valid, wrapping FFT_LEN-1 -> 0.
REQ-027 Full-scale case: src_real=src_imag=-2^(FFT_W-1) gives 2^(2*FFT_W-1) with no overflow.

Reset
REQ-028 Asserted sys_rst_n: FSM=IDLE, counters=0, holding register empty, all outputs 0, including mid-frame (no eop emitted).
REQ-029 After release, framing restarts only at REQ-020 conditions.

Configuration
REQ-030 Macro SPEC_PEAK_EN defined: per frame, track the maximum mag_data over bins 1..FFT_LEN-1 (DC excluded); strict greater-than, so lowest bin wins ties; peak_valid pulses 1 cycle the cycle after mag_eop with peak_bin/peak_mag held until the next pulse.
REQ-031 SPEC_PEAK_EN undefined: peak logic absent; peak_valid, peak_bin, peak_mag tied 0.

Structure
REQ-032 Package spec_pkg holds the FSM state typedef and the width-helper constants/functions.
REQ-033 Sub-module spec_mag_sq implements the 2-stage magnitude pipeline with framing delay; the framer, overrun, and peak logic stay in spec_frame_ctrl.

Verification (FFT_LEN=8, ADC_W=10, FFT_W=12)
REQ-034 adc_data 0, 512, 1023 -> sink_real -512, 0, +511.
REQ-035 20 strobes, sink_ready=1, frm_en=1 -> two frames; sop at transfers 0 and 8, eop at transfers 7 and 15.
REQ-036 sink_ready low 3 cycles mid-frame with strobes every cycle -> ovr_flag=1, frame still 8 transfers; ovr_clr -> 0.
REQ-037 src re/im (3,4) -> mag_data 25 two cycles later; (-2048,-2048) -> 8388608.
REQ-038 SPEC_PEAK_EN, bins 0..7 mags 100,5,9,9,1,0,0,0 -> peak_bin 2, peak_mag 9, peak_valid one cycle after mag_eop.
REQ-039 sys_rst_n low at transfer 4 -> all outputs 0 immediately; after release, next frame starts with sop at count 0.
